oped_debug_hub: RTL and testbench

OPED_DEBUG_HUB -- requirements
Module: oped_debug_hub

---
 rtl/oped_debug_pkg.sv | 17 +
 rtl/oped_edge_counter.sv | 56 +++++
 rtl/oped_debug_hub.sv | 150 +++++++++++++++
 tb/tb_oped_debug_hub.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oped_debug_pkg.sv
// oped_debug_pkg
// Shared definitions for the debug hub: default channel and counter widths
// and the trigger state machine encoding.
package oped_debug_pkg;

  localparam int DEF_DW = 32;  // default width of one debug channel
  localparam int DEF_CW = 16;  // default width of the event counter

  // Trigger state machine. IDLE: tracking. ARMED: waiting for a trigger edge.
  // FROZEN: debug_out holds the snapshot taken in the edge cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    FROZEN = 2'd2
  } oped_state_e;

endpackage

// File: rtl/oped_edge_counter.sv
// oped_edge_counter
// Rising-edge detector on the trigger term plus a saturating event counter.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   trig       in   current trigger term
//   reload     in   selected channel changed this cycle: trig_q is refreshed
//                   and no edge is reported
//   clr        in   zero the counter next cycle (wins over an edge)
//   count      out  saturating count of trigger rising edges
//   trig_edge  out  combinational edge strobe for the current cycle
module oped_edge_counter
  import oped_debug_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          trig,
  input  logic          reload,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          trig_edge
);

  logic          trig_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // trig_q always follows trig; a reload only suppresses the edge, so the
  // history after a channel switch belongs to the new channel.
  assign trig_edge = trig & ~trig_q & ~reload;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (trig_edge && (count_q != {CW{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      trig_q  <= 1'b0;
      count_q <= '0;
    end else begin
      trig_q  <= trig;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/oped_debug_hub.sv
// oped_debug_hub
// Aggregates NCHAN debug channels: registers the selected channel, keeps an
// OR-sticky view of it, counts trigger rising edges, and can freeze a snapshot
// on a masked trigger edge after being armed.
//
// Optional feature: define OPED_DEBUG_TIMESTAMP_EN to build a free-running
// 32b cycle counter whose value is captured into trig_time on freeze. Without
// it trig_time is constant 0.
//
// Ports:
//   CLK, RST_N   clock (rising edge) and asynchronous active-low reset
//   debug_in     NCHAN*DW concatenated channels, channel 0 in the LSBs
//   sel          channel select; values >= NCHAN select all-zero
//   trig_mask    bits of the selected channel forming the trigger
//   arm, clr     single-cycle request pulses (no handshake: sampled each
//                cycle, clr has priority over arm and over a trigger edge)
//   debug_out    registered selected channel, or frozen snapshot
//   sticky_out   OR-accumulation of the selected channel since last clr
//   evt_count    saturating count of trigger rising edges
//   frozen       high while in FROZEN
//   trig_time    cycle stamp of the freeze (0 without the timestamp feature)
//   state_o      current trigger state, for observation
module oped_debug_hub
  import oped_debug_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  localparam int SW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NCHAN*DW-1:0] debug_in,
  input  logic [SW-1:0]     sel,
  input  logic [DW-1:0]     trig_mask,
  input  logic              arm,
  input  logic              clr,
  output logic [DW-1:0]     debug_out,
  output logic [DW-1:0]     sticky_out,
  output logic [CW-1:0]     evt_count,
  output logic              frozen,
  output logic [31:0]       trig_time,
  output logic [1:0]        state_o
);

  oped_state_e   state_q, state_d;
  logic [DW-1:0] debug_out_q, debug_out_d;
  logic [DW-1:0] sticky_q, sticky_d;
  logic [SW-1:0] sel_q;
  logic [DW-1:0] selected;
  logic          trig;
  logic          sel_changed;
  logic          trig_edge;

  // Explicit compare per channel so an out-of-range select yields zero
  // instead of an out-of-bounds part-select.
  always_comb begin
    selected = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (sel == SW'(i)) begin
        selected = debug_in[i*DW +: DW];
      end
    end
  end

  assign trig        = |(selected & trig_mask);
  assign sel_changed = (sel != sel_q);

  oped_edge_counter #(
    .CW(CW)
  ) u_edge_counter (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .trig     (trig),
    .reload   (sel_changed),
    .clr      (clr),
    .count    (evt_count),
    .trig_edge(trig_edge)
  );

  // An edge seen in IDLE together with arm only arms; it does not freeze.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm)       state_d = ARMED;
        ARMED:   if (trig_edge) state_d = FROZEN;
        FROZEN:  state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end
  end

  // In the edge cycle the state is still ARMED, so the snapshot held while
  // FROZEN is the sample of the edge cycle itself.
  always_comb begin
    debug_out_d = (state_q == FROZEN) ? debug_out_q : selected;
    sticky_d    = clr ? '0 : (sticky_q | selected);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      debug_out_q <= '0;
      sticky_q    <= '0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      debug_out_q <= debug_out_d;
      sticky_q    <= sticky_d;
      sel_q       <= sel;
    end
  end

`ifdef OPED_DEBUG_TIMESTAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] trig_time_q, trig_time_d;

  always_comb begin
    trig_time_d = trig_time_q;
    if (clr) begin
      trig_time_d = '0;
    end else if ((state_q == ARMED) && (state_d == FROZEN)) begin
      trig_time_d = cyc_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc_q       <= '0;
      trig_time_q <= '0;
    end else begin
      cyc_q       <= cyc_q + 32'd1;
      trig_time_q <= trig_time_d;
    end
  end

  assign trig_time = trig_time_q;
`else
  assign trig_time = '0;
`endif

  assign debug_out  = debug_out_q;
  assign sticky_out = sticky_q;
  assign frozen     = (state_q == FROZEN);
  assign state_o    = state_q;

endmodule

// File: tb/tb_oped_debug_hub.sv
// tb_oped_debug_hub
// Directed bench for oped_debug_hub. Main DUT: NCHAN=4, DW=32, CW=4.
// A second instance with NCHAN=3 exercises an out-of-range select, which a
// 2-bit select cannot reach when NCHAN=4.
module tb_oped_debug_hub;

  localparam int DW = 32;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- main DUT ----------------
  logic [4*DW-1:0] debug_in;
  logic [1:0]      sel;
  logic [DW-1:0]   trig_mask;
  logic            arm, clr;
  logic [DW-1:0]   debug_out, sticky_out;
  logic [CW-1:0]   evt_count;
  logic            frozen;
  logic [31:0]     trig_time;
  logic [1:0]      state_o;

  oped_debug_hub #(.NCHAN(4), .DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .debug_in(debug_in), .sel(sel),
    .trig_mask(trig_mask), .arm(arm), .clr(clr), .debug_out(debug_out),
    .sticky_out(sticky_out), .evt_count(evt_count), .frozen(frozen),
    .trig_time(trig_time), .state_o(state_o)
  );

  // ---------------- NCHAN=3 DUT ----------------
  logic [3*DW-1:0] debug_in_b;
  logic [1:0]      sel_b;
  logic [DW-1:0]   debug_out_b, sticky_out_b;
  logic [CW-1:0]   evt_count_b;
  logic            frozen_b;
  logic [31:0]     trig_time_b;
  logic [1:0]      state_b;

  oped_debug_hub #(.NCHAN(3), .DW(DW), .CW(CW)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .debug_in(debug_in_b), .sel(sel_b),
    .trig_mask(32'h0), .arm(1'b0), .clr(1'b0), .debug_out(debug_out_b),
    .sticky_out(sticky_out_b), .evt_count(evt_count_b), .frozen(frozen_b),
    .trig_time(trig_time_b), .state_o(state_b)
  );

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_FROZEN = 2'd2;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] v);
    debug_in[ch*DW +: DW] = v;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  logic [31:0] exp_ts;

  initial begin
    debug_in   = '0;
    sel        = 2'd0;
    trig_mask  = '0;
    arm        = 1'b0;
    clr        = 1'b0;
    debug_in_b = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    sel_b      = 2'd0;
    set_ch(1, 32'hDEAD_BEEF);

    // ---- reset state ----
    repeat (3) @(posedge CLK);
    #1;
    check("rst_debug_out", debug_out, 32'h0);
    check("rst_sticky", sticky_out, 32'h0);
    check("rst_evt", 32'(evt_count), 32'h0);
    check("rst_frozen", 32'(frozen), 32'h0);
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    check("rst_trig_time", trig_time, 32'h0);
    RST_N = 1'b1;

    // ---- channel select, 1-cycle latency ----
    set_ch(2, 32'hA5A5_0000);
    sel = 2'd2;
    check("sel2_before_edge", debug_out, 32'h0);
    step();
    check("sel2_debug_out", debug_out, 32'hA5A5_0000);
    sel = 2'd1;
    step();
    check("sel1_debug_out", debug_out, 32'hDEAD_BEEF);

    sel_b = 2'd2;
    step();
    check("b_sel2", debug_out_b, 32'h3333_3333);
    sel_b = 2'd3;
    step();
    check("b_sel_out_of_range", debug_out_b, 32'h0);

    // ---- sticky accumulation and clear ----
    debug_in = '0;
    sel      = 2'd0;
    pulse_clr();
    check("sticky_after_clr0", sticky_out, 32'h0);
    set_ch(0, 32'h1);
    step();
    set_ch(0, 32'h100);
    step();
    set_ch(0, 32'h0);
    check("sticky_accum", sticky_out, 32'h101);
    step();
    check("sticky_hold", sticky_out, 32'h101);
    pulse_clr();
    check("sticky_clr", sticky_out, 32'h0);
    check("evt_unmasked_zero", 32'(evt_count), 32'h0);

    // ---- arm and freeze ----
    trig_mask = 32'h1;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("armed_state", 32'(state_o), 32'(S_ARMED));
    check("armed_not_frozen", 32'(frozen), 32'h0);
    set_ch(0, 32'h3);
    step();
    check("frozen_flag", 32'(frozen), 32'h1);
    check("frozen_snapshot", debug_out, 32'h3);
    check("frozen_evt1", 32'(evt_count), 32'h1);
    set_ch(0, 32'h5);
    step();
    set_ch(0, 32'h8);
    step();
    set_ch(0, 32'h9);
    step();
    check("frozen_hold", debug_out, 32'h3);
    check("frozen_evt2", 32'(evt_count), 32'h2);
    check("frozen_sticky", sticky_out, 32'hF);
    arm = 1'b1;
    step();
    check("arm_ignored_frozen", 32'(state_o), 32'(S_FROZEN));

    // ---- clr with arm in the same cycle ----
    clr = 1'b1;
    step();
    clr = 1'b0;
    arm = 1'b0;
    check("clr_arm_state", 32'(state_o), 32'(S_IDLE));
    check("clr_arm_frozen", 32'(frozen), 32'h0);
    check("clr_evt", 32'(evt_count), 32'h0);
    step();
    check("resume_tracking", debug_out, 32'h9);

    // ---- saturating counter, 20 edges ----
    set_ch(0, 32'h0);
    step();
    for (int i = 0; i < 20; i++) begin
      set_ch(0, 32'h1);
      step();
      set_ch(0, 32'h0);
      step();
      if (i == 4) check("evt_count_5", 32'(evt_count), 32'h5);
    end
    check("evt_saturated", 32'(evt_count), 32'hF);

    // ---- sel change never counts ----
    set_ch(0, 32'h1);
    set_ch(1, 32'h1);
    step();
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      sel = (sel == 2'd0) ? 2'd1 : 2'd0;
      step();
    end
    check("sel_toggle_both_high", 32'(evt_count), 32'h0);
    set_ch(0, 32'h0);
    step();
    for (int i = 0; i < 6; i++) begin
      sel = (sel == 2'd0) ? 2'd1 : 2'd0;
      step();
    end
    check("sel_toggle_reload", 32'(evt_count), 32'h0);

    // ---- asynchronous reset while FROZEN ----
    sel = 2'd0;
    set_ch(0, 32'h0);
    set_ch(1, 32'h0);
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    set_ch(0, 32'h7);
    step();
    check("refreeze", 32'(frozen), 32'h1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_debug_out", debug_out, 32'h0);
    check("async_rst_sticky", sticky_out, 32'h0);
    check("async_rst_evt", 32'(evt_count), 32'h0);
    check("async_rst_frozen", 32'(frozen), 32'h0);
    check("async_rst_state", 32'(state_o), 32'(S_IDLE));

    // ---- freeze timestamp: edge sampled on the 101st clock after release ----
    set_ch(0, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (99) step();
    set_ch(0, 32'h1);
    step();
`ifdef OPED_DEBUG_TIMESTAMP_EN
    exp_ts = 32'd100;
`else
    exp_ts = 32'd0;
`endif
    exp_q.push_back(exp_ts);
    check("ts_frozen", 32'(frozen), 32'h1);
    check("ts_trig_time", trig_time, exp_q.pop_front());
    pulse_clr();
    check("ts_clr", trig_time, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
